// File: rtl/dplca_txop_table_writer_pkg.sv
// Shared definitions for the DPLCA TXOP table writer: table geometry, age defaults and FSM states.
package dplca_txop_table_writer_pkg;

   localparam int unsigned NODE_ID_W   = 8;
   localparam int unsigned TABLE_DEPTH = 256;
   localparam int unsigned DEF_AGE_W   = 4;
   localparam int unsigned DEF_MAX_AGE = 8;

   typedef enum logic [1:0] {
      StClearing = 2'd0,
      StIdle     = 2'd1,
      StAging    = 2'd2
   } state_e;

endpackage

// File: rtl/dplca_age_ram.sv
// 256-entry age storage: one synchronous write port, asynchronous sweep and query read ports.
module dplca_age_ram
   import dplca_txop_table_writer_pkg::*;
#(
   parameter int unsigned AGE_W = DEF_AGE_W
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [NODE_ID_W-1:0] waddr,
   input  logic [AGE_W-1:0]     wdata,
   input  logic [NODE_ID_W-1:0] sweep_addr,
   output logic [AGE_W-1:0]     sweep_data,
   input  logic [NODE_ID_W-1:0] query_addr,
   output logic [AGE_W-1:0]     query_data
);

   // Not reset: the parent's clearing sweep initialises every entry.
   logic [AGE_W-1:0] mem [TABLE_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign sweep_data = mem[sweep_addr];
   assign query_data = mem[query_addr];

endmodule

// File: rtl/dplca_txop_table_writer.sv
// DPLCA TXOP table write side: marks claimed node IDs, ages them on BEACON, publishes
// MAX_CLAIM / PICK_FREE_TXOP results and serves a registered CLAIMING lookup.
module dplca_txop_table_writer
   import dplca_txop_table_writer_pkg::*;
#(
   parameter int unsigned AGE_W   = DEF_AGE_W,
   parameter int unsigned MAX_AGE = DEF_MAX_AGE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear_req,
   output logic                 clear_done,
   input  logic                 beacon_seen,
   input  logic                 txop_valid,
   input  logic [NODE_ID_W-1:0] txop_id,
   input  logic                 txop_used,
   input  logic [NODE_ID_W-1:0] query_id,
   output logic                 claiming,
   output logic [NODE_ID_W-1:0] max_claim,
   output logic [NODE_ID_W-1:0] free_txop,
   output logic                 free_valid,
   output logic                 busy,
   output logic                 overrun
);

   localparam logic [NODE_ID_W-1:0] LastIdx = NODE_ID_W'(TABLE_DEPTH - 1);

   state_e                 state_q, state_d;
   logic [NODE_ID_W-1:0]   idx_q, idx_d;
   logic [NODE_ID_W-1:0]   max_run_q, max_run_d;
   logic [NODE_ID_W-1:0]   free_run_q, free_run_d;
   logic                   free_run_valid_q, free_run_valid_d;
   logic                   free_stale_q, free_stale_d;

   logic                   we;
   logic [NODE_ID_W-1:0]   waddr;
   logic [AGE_W-1:0]       wdata;
   logic [AGE_W-1:0]       sweep_data, query_data, aged;
   logic                   txop_wr, hit, live, publish;

   dplca_age_ram #(
      .AGE_W (AGE_W)
   ) u_age_ram (
      .clk        (clk),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .sweep_addr (idx_q),
      .sweep_data (sweep_data),
      .query_addr (query_id),
      .query_data (query_data)
   );

   assign txop_wr = txop_valid && txop_used;
   assign aged    = (sweep_data == '0) ? '0 : sweep_data - AGE_W'(1);
   // A same-cycle refresh of the swept entry wins over its decrement.
   assign hit     = txop_wr && (txop_id == idx_q);
   assign live    = hit || (aged != '0);
   assign publish = !clear_req && (state_q == StAging) && (idx_q == LastIdx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StClearing;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear_req) begin
         state_d = StClearing;
      end else begin
         unique case (state_q)
            StClearing: if (idx_q == LastIdx) state_d = StIdle;
            StIdle:     if (beacon_seen)      state_d = StAging;
            StAging:    if (idx_q == LastIdx) state_d = StIdle;
            default:                          state_d = StClearing;
         endcase
      end
   end

   // Write mux priority: clear sweep > txop update > aging write-back.
   always_comb begin
      busy  = (state_q != StIdle);
      we    = 1'b0;
      waddr = idx_q;
      wdata = '0;
      unique case (state_q)
         StClearing: we = 1'b1;
         StIdle: begin
            if (txop_wr) begin
               we    = 1'b1;
               waddr = txop_id;
               wdata = AGE_W'(MAX_AGE);
            end
         end
         StAging: begin
            we = 1'b1;
            if (txop_wr) begin
               waddr = txop_id;
               wdata = AGE_W'(MAX_AGE);
            end else begin
               wdata = aged;
            end
         end
         default: we = 1'b0;
      endcase
   end

   always_comb begin
      idx_d            = idx_q;
      max_run_d        = max_run_q;
      free_run_d       = free_run_q;
      free_run_valid_d = free_run_valid_q;
      free_stale_d     = free_stale_q;
      if (clear_req) begin
         idx_d = '0;
      end else if (state_q == StIdle) begin
         if (beacon_seen) begin
            idx_d            = '0;
            max_run_d        = '0;
            free_run_d       = '0;
            free_run_valid_d = 1'b0;
            free_stale_d     = 1'b0;
         end
      end else begin
         idx_d = idx_q + NODE_ID_W'(1);
         if (state_q == StAging) begin
            if (live) begin
               max_run_d = idx_q;
            end else if ((idx_q != '0) && !free_run_valid_q) begin
               free_run_d       = idx_q;
               free_run_valid_d = 1'b1;
            end
            // Refresh of an already-swept entry must still be reflected in the results.
            if (txop_wr && (txop_id < idx_q)) begin
               if (txop_id > max_run_d) max_run_d = txop_id;
               if (free_run_valid_q && (txop_id == free_run_q)) free_stale_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q            <= '0;
         max_run_q        <= '0;
         free_run_q       <= '0;
         free_run_valid_q <= 1'b0;
         free_stale_q     <= 1'b0;
         clear_done       <= 1'b0;
         claiming         <= 1'b0;
         max_claim        <= '0;
         free_txop        <= '0;
         free_valid       <= 1'b0;
         overrun          <= 1'b0;
      end else begin
         idx_q            <= idx_d;
         max_run_q        <= max_run_d;
         free_run_q       <= free_run_d;
         free_run_valid_q <= free_run_valid_d;
         free_stale_q     <= free_stale_d;
         if (clear_req) begin
            clear_done <= 1'b0;
         end else if ((state_q == StClearing) && (idx_q == LastIdx)) begin
            clear_done <= 1'b1;
         end
         if (publish) begin
            max_claim  <= max_run_d;
            free_txop  <= free_run_d;
            free_valid <= free_run_valid_d && !free_stale_d;
         end
         overrun  <= (state_q == StAging) && beacon_seen;
         claiming <= (state_q != StClearing) &&
                     ((we && (waddr == query_id)) ? (wdata != '0) : (query_data != '0));
      end
   end

endmodule

// File: tb/tb_dplca_txop_table_writer.sv
// Directed bench for the DPLCA TXOP table writer: clear sweep, marking, aging, clear and overrun.
module tb_dplca_txop_table_writer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear_req = 1'b0;
   logic       clear_done;
   logic       beacon_seen = 1'b0;
   logic       txop_valid = 1'b0;
   logic [7:0] txop_id = 8'd0;
   logic       txop_used = 1'b0;
   logic [7:0] query_id = 8'd0;
   logic       claiming;
   logic [7:0] max_claim;
   logic [7:0] free_txop;
   logic       free_valid;
   logic       busy;
   logic       overrun;

   int n_checks = 0;
   int n_fails  = 0;

   dplca_txop_table_writer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_req   (clear_req),
      .clear_done  (clear_done),
      .beacon_seen (beacon_seen),
      .txop_valid  (txop_valid),
      .txop_id     (txop_id),
      .txop_used   (txop_used),
      .query_id    (query_id),
      .claiming    (claiming),
      .max_claim   (max_claim),
      .free_txop   (free_txop),
      .free_valid  (free_valid),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Each step ends just after a rising edge, on the falling edge.
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Beacon sampled at edge B; results are visible after edge B+256.
   task automatic beacon_sweep();
      beacon_seen = 1'b1;
      cyc(1);
      beacon_seen = 1'b0;
      cyc(256);
   endtask

   initial begin
      cyc(1);
      check("rst_clear_done", 32'(clear_done), 32'd0);
      check("rst_claiming",   32'(claiming),   32'd0);
      check("rst_max_claim",  32'(max_claim),  32'd0);
      check("rst_free_txop",  32'(free_txop),  32'd0);
      check("rst_free_valid", 32'(free_valid), 32'd0);
      check("rst_busy",       32'(busy),       32'd1);
      check("rst_overrun",    32'(overrun),    32'd0);

      // Clearing sweep after reset release: 256 edges.
      rst_n = 1'b1;
      cyc(100);
      check("clr_claiming_forced", 32'(claiming), 32'd0);
      check("clr_busy_mid",        32'(busy),     32'd1);
      cyc(155);
      check("clr_done_at_255", 32'(clear_done), 32'd0);
      cyc(1);
      check("clr_done_at_256", 32'(clear_done), 32'd1);
      check("clr_busy_done",   32'(busy),       32'd0);
      query_id = 8'd7;
      cyc(1);
      check("clr_claiming_7", 32'(claiming), 32'd0);

      // Marking and write-first lookup.
      txop_valid = 1'b1; txop_used = 1'b1; txop_id = 8'd5; query_id = 8'd5;
      cyc(1);
      check("mark5_write_first", 32'(claiming), 32'd1);
      txop_used = 1'b0; txop_id = 8'd6; query_id = 8'd6;
      cyc(1);
      check("unused6_claiming", 32'(claiming), 32'd0);
      txop_valid = 1'b0; query_id = 8'd5;
      cyc(1);
      check("mark5_claiming", 32'(claiming), 32'd1);

      // Mark 3 and 200, then age.
      txop_valid = 1'b1; txop_used = 1'b1; txop_id = 8'd3;
      cyc(1);
      txop_id = 8'd200;
      cyc(1);
      txop_valid = 1'b0;
      beacon_seen = 1'b1;
      cyc(1);
      beacon_seen = 1'b0;
      check("age1_busy_start", 32'(busy), 32'd1);
      cyc(255);
      check("age1_not_published", 32'(max_claim), 32'd0);
      check("age1_busy_255",      32'(busy),      32'd1);
      cyc(1);
      check("age1_max_claim",  32'(max_claim),  32'd200);
      check("age1_free_txop",  32'(free_txop),  32'd1);
      check("age1_free_valid", 32'(free_valid), 32'd1);
      check("age1_busy_end",   32'(busy),       32'd0);
      for (int k = 1; k <= 8; k++) begin
         beacon_sweep();
         if (k == 6) check("age_k6_max_claim", 32'(max_claim), 32'd200);
      end
      check("age_k8_max_claim", 32'(max_claim), 32'd0);
      query_id = 8'd200;
      cyc(1);
      check("age_k8_claiming200", 32'(claiming), 32'd0);

      // Mark every ID 1..255: nothing free.
      txop_valid = 1'b1; txop_used = 1'b1;
      for (int i = 1; i <= 255; i++) begin
         txop_id = 8'(i);
         cyc(1);
      end
      txop_valid = 1'b0;
      beacon_sweep();
      check("full_free_valid", 32'(free_valid), 32'd0);
      check("full_max_claim",  32'(max_claim),  32'd255);

      // Refresh ID 50 in the very cycle the sweep visits it.
      beacon_seen = 1'b1;
      cyc(1);
      beacon_seen = 1'b0;
      cyc(50);
      txop_valid = 1'b1; txop_used = 1'b1; txop_id = 8'd50; query_id = 8'd50;
      cyc(1);
      txop_valid = 1'b0;
      check("hit50_claiming", 32'(claiming), 32'd1);
      cyc(205);
      check("hit50_max_claim", 32'(max_claim), 32'd255);
      // Others now at 6, ID 50 at MAX_AGE; after 7 more sweeps only ID 50 (age 1) survives.
      repeat (7) beacon_sweep();
      check("hit50_survivor_max", 32'(max_claim),  32'd50);
      check("hit50_free_txop",    32'(free_txop),  32'd1);
      check("hit50_free_valid",   32'(free_valid), 32'd1);
      cyc(1);
      check("hit50_claiming_late", 32'(claiming), 32'd1);

      // Clear request in the middle of an aging sweep.
      beacon_seen = 1'b1;
      cyc(1);
      beacon_seen = 1'b0;
      cyc(100);
      clear_req = 1'b1;
      cyc(1);
      clear_req = 1'b0;
      check("midclr_done_low", 32'(clear_done), 32'd0);
      check("midclr_busy",     32'(busy),       32'd1);
      cyc(255);
      check("midclr_done_255", 32'(clear_done), 32'd0);
      cyc(1);
      check("midclr_done_256",  32'(clear_done), 32'd1);
      check("midclr_max_kept",  32'(max_claim),  32'd50);
      check("midclr_free_kept", 32'(free_valid), 32'd1);
      cyc(1);
      check("midclr_claiming50", 32'(claiming), 32'd0);

      // Second beacon while aging.
      beacon_seen = 1'b1;
      cyc(1);
      beacon_seen = 1'b0;
      cyc(10);
      beacon_seen = 1'b1;
      cyc(1);
      beacon_seen = 1'b0;
      check("ovr_pulse", 32'(overrun), 32'd1);
      cyc(1);
      check("ovr_one_cycle", 32'(overrun), 32'd0);
      cyc(243);
      check("ovr_busy_255", 32'(busy), 32'd1);
      cyc(1);
      check("ovr_busy_256",   32'(busy),       32'd0);
      check("ovr_max_claim",  32'(max_claim),  32'd0);
      check("ovr_free_txop",  32'(free_txop),  32'd1);
      check("ovr_free_valid", 32'(free_valid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
